// File: rtl/encrypt_cbc_ctrl.sv
// encrypt_cbc_ctrl: stream front end for the encrypt_v2 PRESENT-80 core.
// Takes one plaintext block at a time from a valid/ready stream and runs the
// 4-phase req/ack handshake with encrypt_v2. The ciphertext is then presented
// on a valid/ready output stream.
// Build option: define CBC_CHAIN_EN to enable CBC chaining. When it is not
// defined, the block runs in plain ECB mode.
module encrypt_cbc_ctrl #(
  parameter int unsigned b     = 64,
  parameter int unsigned k     = 80,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [b-1:0]     in_M,
  input  logic [k-1:0]     in_K,
  input  logic [b-1:0]     in_IV,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [b-1:0]     out_C,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             enc_req,
  input  logic             enc_ack,
  output logic [k-1:0]     enc_K,
  output logic [b-1:0]     enc_M,
  input  logic [b-1:0]     enc_C
);

  typedef enum logic [1:0] {StIdle, StReq, StRel, StOut} state_e;

  state_e       state_q;
  logic         first_q;
  logic         accept;
  logic [b-1:0] blk_m;

  // Accept only in idle, and only after encrypt_v2 has dropped any ack that is
  // still pending from before a reset. in_ready is also forced low in reset.
  assign in_ready = rst_n && (state_q == StIdle) && !enc_ack;
  assign accept   = in_valid && in_ready;

`ifdef CBC_CHAIN_EN
  logic [b-1:0] chain_q;

  // Chaining operand is chosen when the block is accepted.
  assign blk_m = in_M ^ (in_first ? in_IV : chain_q);

  // Chain register tracks the most recent ciphertext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else if (state_q == StReq && enc_ack) begin
      chain_q <= enc_C;
    end
  end
`else
  logic unused_iv;

  assign unused_iv = ^in_IV;
  assign blk_m     = in_M;
`endif

  // Handshake FSM. All outputs except in_ready are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      first_q   <= 1'b0;
      enc_req   <= 1'b0;
      enc_K     <= '0;
      enc_M     <= '0;
      out_valid <= 1'b0;
      out_C     <= '0;
      blk_cnt   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            enc_K   <= in_K;
            enc_M   <= blk_m;
            first_q <= in_first;
            enc_req <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (enc_ack) begin
            out_C   <= enc_C;
            // A chain start restarts the count, so its own block counts as 1.
            blk_cnt <= first_q ? CNT_W'(1) : blk_cnt + CNT_W'(1);
            enc_req <= 1'b0;
            state_q <= StRel;
          end
        end
        StRel: begin
          if (!enc_ack) begin
            out_valid <= 1'b1;
            state_q   <= StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt_cbc_ctrl.sv
// Bench for encrypt_cbc_ctrl. A behavioural PRESENT-80 responder plays the
// role of encrypt_v2, and ack timing is randomised. Expected ciphertexts come
// from a block-level model of ECB/CBC chaining and block counting.
`timescale 1ns/1ps
module tb_encrypt_cbc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_M;
  logic [79:0] in_K;
  logic [63:0] in_IV;
  logic        in_first;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_C;
  logic [15:0] blk_cnt;
  logic        enc_req;
  logic        enc_ack;
  logic [79:0] enc_K;
  logic [63:0] enc_M;
  logic [63:0] enc_C;

  int errs   = 0;
  int checks = 0;

  encrypt_cbc_ctrl #(.b(64), .k(80), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_M      (in_M),
    .in_K      (in_K),
    .in_IV     (in_IV),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_C     (out_C),
    .blk_cnt   (blk_cnt),
    .enc_req   (enc_req),
    .enc_ack   (enc_ack),
    .enc_K     (enc_K),
    .enc_M     (enc_M),
    .enc_C     (enc_C)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // PRESENT-80 reference cipher.
  function automatic logic [63:0] present80(input logic [79:0] key_in, input logic [63:0] pt);
    logic [63:0] sbox;
    logic [79:0] key;
    logic [63:0] st;
    logic [63:0] tmp;
    logic [4:0]  rc;
    sbox = 64'h21748FE3DA09B65C;
    key  = key_in;
    st   = pt;
    for (int r = 1; r <= 31; r++) begin
      st = st ^ key[79:16];
      for (int n = 0; n < 16; n++) tmp[4*n +: 4] = sbox[4*st[4*n +: 4] +: 4];
      st = tmp;
      for (int i = 0; i < 63; i++) tmp[(i*16) % 63] = st[i];
      tmp[63] = st[63];
      st = tmp;
      key = {key[18:0], key[79:19]};
      key[79:76] = sbox[4*key[79:76] +: 4];
      rc = 5'(r);
      key[19:15] = key[19:15] ^ rc;
    end
    return st ^ key[79:16];
  endfunction

  // encrypt_v2 stand-in: random ack latency on both handshake phases. It is
  // not reset by rst_n, so a pending ack survives a controller reset.
  int          s_lat = 0;
  logic [63:0] s_m;
  logic [79:0] s_k;
  int          s_rst;
  int          rst_events = 0;
  int          hold_seen  = 0;
  int          hold_bad   = 0;
  int          viol       = 0;

  initial begin
    enc_ack = 1'b0;
    enc_C   = '0;
    forever begin
      @(negedge clk);
      if (!enc_ack) begin
        if (enc_req) begin
          if (s_lat == 0) begin
            enc_C   = present80(enc_K, enc_M);
            s_m     = enc_M;
            s_k     = enc_K;
            s_rst   = rst_events;
            enc_ack = 1'b1;
            s_lat   = int'($urandom_range(0, 3));
          end else s_lat--;
        end
      end else if (!enc_req) begin
        if (s_lat == 0) begin
          if (s_rst == rst_events) begin
            hold_seen++;
            if (enc_M !== s_m || enc_K !== s_k) hold_bad++;
          end
          enc_ack = 1'b0;
          s_lat   = int'($urandom_range(0, 3));
        end else s_lat--;
      end
    end
  end

  // Count resets so that handshakes cut by a reset are skipped by the hold check.
  always @(negedge rst_n) rst_events++;

  // enc_req must never rise while an ack is still high.
  always @(posedge enc_req) if (enc_ack) viol++;

  // Block-level model.
  logic [63:0] mdl_chain;
  logic [15:0] mdl_cnt;
  logic [63:0] exp_c_q[$];
  logic [15:0] exp_n_q[$];

  task automatic model_reset();
    mdl_chain = '0;
    mdl_cnt   = '0;
    exp_c_q.delete();
    exp_n_q.delete();
  endtask

  task automatic send_block(input string tag, input logic [63:0] m, input logic [79:0] key,
                            input logic [63:0] iv, input logic first);
    logic [63:0] m_eff;
    logic [63:0] c;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_M     = m;
    in_K     = key;
    in_IV    = iv;
    in_first = first;
    n = 0;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check_eq({tag, "_accept_timeout"}, 80'd0, 80'd1);
      in_valid = 1'b0;
      return;
    end
`ifdef CBC_CHAIN_EN
    m_eff = m ^ (first ? iv : mdl_chain);
`else
    m_eff = m;
`endif
    c         = present80(key, m_eff);
    mdl_chain = c;
    mdl_cnt   = first ? 16'd1 : mdl_cnt + 16'd1;
    exp_c_q.push_back(c);
    exp_n_q.push_back(mdl_cnt);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq({tag, "_req"}, 80'(enc_req), 80'd1);
    check_eq({tag, "_enc_M"}, 80'(enc_M), 80'(m_eff));
    check_eq({tag, "_enc_K"}, enc_K, key);
  endtask

  logic ready_keep = 1'b0;

  task automatic recv_block(input string tag, input int hold, output logic [63:0] c,
                            output logic [15:0] cnt);
    int n;
    int bad;
    c   = '0;
    cnt = '0;
    @(negedge clk);
    #1;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      check_eq({tag, "_out_timeout"}, 80'd0, 80'd1);
      return;
    end
    c   = out_C;
    cnt = blk_cnt;
    if (exp_c_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, 80'd0, 80'd1);
    end else begin
      check_eq({tag, "_C"}, 80'(c), 80'(exp_c_q.pop_front()));
      check_eq({tag, "_cnt"}, 80'(cnt), 80'(exp_n_q.pop_front()));
    end
    if (hold > 0) begin
      bad = 0;
      repeat (hold) begin
        @(negedge clk);
        #1;
        if (out_C !== c || in_ready !== 1'b0 || enc_req !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      check_eq({tag, "_hold"}, 80'(bad), 80'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (!ready_keep) out_ready = 1'b0;
    check_eq({tag, "_valid_fall"}, 80'(out_valid), 80'd0);
  endtask

  logic [63:0] c;
  logic [15:0] cnt;
  int n;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_M     = '0;
    in_K     = '0;
    in_IV    = '0;
    in_first = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_in_ready", 80'(in_ready), 80'd0);
    check_eq("rst_out_valid", 80'(out_valid), 80'd0);
    check_eq("rst_enc_req", 80'(enc_req), 80'd0);
    check_eq("rst_out_C", 80'(out_C), 80'd0);
    check_eq("rst_enc_K", enc_K, 80'd0);
    check_eq("rst_enc_M", 80'(enc_M), 80'd0);
    check_eq("rst_blk_cnt", 80'(blk_cnt), 80'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_in_ready", 80'(in_ready), 80'd1);

    // All-zero key and plaintext.
    send_block("t1", 64'h0, 80'h0, 64'h0, 1'b1);
    recv_block("t1", 0, c, cnt);
    check_eq("t1_const", 80'(c), 80'h5579c1387b228445);
    check_eq("t1_cnt1", 80'(cnt), 80'd1);

    // Feed the previous ciphertext back in as plaintext.
    send_block("t2", 64'h5579c1387b228445, 80'h0, 64'h0, 1'b0);
    recv_block("t2", 0, c, cnt);
`ifdef CBC_CHAIN_EN
    check_eq("t2_const", 80'(c), 80'h5579c1387b228445);
`else
    check_eq("t2_differs", 80'(c != 64'h5579c1387b228445), 80'd1);
`endif
    check_eq("t2_cnt2", 80'(cnt), 80'd2);

    send_block("t3a", 64'h0, {80{1'b1}}, 64'h0, 1'b1);
    recv_block("t3a", 0, c, cnt);
    check_eq("t3a_const", 80'(c), 80'he72c46c0f5945049);
    send_block("t3b", {64{1'b1}}, 80'h0, 64'h0, 1'b1);
    recv_block("t3b", 0, c, cnt);
    check_eq("t3b_const", 80'(c), 80'ha112ffc72f68417b);

    // Output back-pressure for 20 cycles.
    send_block("t4", {$urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 64'h0, 1'b0);
    recv_block("t4", 20, c, cnt);

    // Reset while the request is up and encrypt_v2 has just acked.
    send_block("t5a", {$urandom, $urandom}, {16'($urandom), $urandom, $urandom}, 64'h0, 1'b0);
    n = 0;
    while (!(enc_req && enc_ack) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("t5_req_ack_seen", 80'(enc_req && enc_ack), 80'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_req_drop", 80'(enc_req), 80'd0);
    check_eq("t5_ready_low", 80'(in_ready), 80'd0);
    check_eq("t5_cnt_clr", 80'(blk_cnt), 80'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    n = 0;
    while (enc_ack && n < 100) begin
      if (in_ready !== 1'b0) n = 1000;
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("t5_ready_held", 80'(n >= 1000), 80'd0);
    check_eq("t5_ack_fell", 80'(enc_ack), 80'd0);
    check_eq("t5_ready_back", 80'(in_ready), 80'd1);
    send_block("t5b", {64{1'b1}}, {80{1'b1}}, 64'h0, 1'b1);
    recv_block("t5b", 0, c, cnt);
    check_eq("t5b_const", 80'(c), 80'h3333dcd3213210d2);
    check_eq("t5b_cnt", 80'(cnt), 80'd1);

    // Back-to-back blocks with out_ready tied high.
    ready_keep = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_block("t6", {$urandom, $urandom}, {16'($urandom), $urandom, $urandom},
                 {$urandom, $urandom}, i == 0);
      recv_block("t6", 0, c, cnt);
      check_eq("t6_cnt_seq", 80'(cnt), 80'(i + 1));
    end
    ready_keep = 1'b0;
    out_ready  = 1'b0;

    // Random traffic: random chain starts and back-pressure.
    for (int i = 0; i < 16; i++) begin
      send_block("rnd", {$urandom, $urandom}, {16'($urandom), $urandom, $urandom},
                 {$urandom, $urandom}, (i == 0) || ($urandom_range(0, 3) == 0));
      recv_block("rnd", int'($urandom_range(0, 3)), c, cnt);
    end

    check_eq("no_req_during_ack", 80'(viol), 80'd0);
    check_eq("enc_inputs_held", 80'(hold_bad), 80'd0);
    check_eq("handshakes_seen", 80'(hold_seen > 20), 80'd1);
    check_eq("no_leftover", 80'(exp_c_q.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
